// File: rtl/stream_acc_pkg.sv
// Shared constants for the stream accumulator: FSM state encoding and default widths.
package stream_acc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 48;
  localparam int DEF_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_add.sv
// Combinational accumulate step: extends one input word to the accumulator width,
// adds it, and flags signed or unsigned overflow of that single addition.
module acc_add
  import stream_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]  acc_in,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  signed_in,
  output logic [ACC_WIDTH-1:0]  sum_out,
  output logic                  overflow_out
);

  logic [ACC_WIDTH-1:0] word_ext_s;
  logic [ACC_WIDTH:0]   wide_s;

  always_comb begin
    word_ext_s = {{(ACC_WIDTH-DATA_WIDTH){signed_in & word_in[DATA_WIDTH-1]}}, word_in};
    wide_s     = {1'b0, acc_in} + {1'b0, word_ext_s};
    sum_out    = wide_s[ACC_WIDTH-1:0];
    // Signed: like-signed operands producing a result of the other sign.
    if (signed_in) begin
      overflow_out = (acc_in[ACC_WIDTH-1] == word_ext_s[ACC_WIDTH-1]) &&
                     (wide_s[ACC_WIDTH-1] != acc_in[ACC_WIDTH-1]);
    end else begin
      overflow_out = wide_s[ACC_WIDTH];
    end
  end

endmodule

// File: rtl/stream_accumulator.sv
// Drains a commanded number of words from a valid/ready FIFO port, sums them into a
// wide accumulator and holds the sum plus sticky overflow on a valid/ready result port.
module stream_accumulator
  import stream_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic [LEN_WIDTH-1:0]  cmdLenIn,
  input  logic                  cmdSignedIn,
  input  logic                  cmdValidIn,
  output logic                  cmdReadyOut,
  input  logic [DATA_WIDTH-1:0] inDataIn,
  input  logic                  inValidIn,
  output logic                  inReadyOut,
  output logic [ACC_WIDTH-1:0]  sumDataOut,
  output logic                  sumOverflowOut,
  output logic                  sumValidOut,
  input  logic                  sumReadyIn,
  output logic                  busyOut
);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 signed_q, signed_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] add_sum_s;
  logic                 add_ovf_s;

  acc_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc_add (
    .acc_in       (acc_q),
    .word_in      (inDataIn),
    .signed_in    (signed_q),
    .sum_out      (add_sum_s),
    .overflow_out (add_ovf_s)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    signed_d = signed_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (cmdValidIn) begin
          rem_d    = cmdLenIn;
          signed_d = cmdSignedIn;
          acc_d    = {ACC_WIDTH{1'b0}};
          ovf_d    = 1'b0;
          if (cmdLenIn == {LEN_WIDTH{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (inValidIn) begin
          acc_d = add_sum_s;
          ovf_d = ovf_q | add_ovf_s;
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (sumReadyIn) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q  <= ST_IDLE;
      rem_q    <= {LEN_WIDTH{1'b0}};
      signed_q <= 1'b0;
      acc_q    <= {ACC_WIDTH{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake outputs come only from the state register; cmd ready is held low while in reset.
  always_comb begin
    cmdReadyOut    = (state_q == ST_IDLE) && !rstIn;
    inReadyOut     = (state_q == ST_ACCUM);
    sumValidOut    = (state_q == ST_DONE);
    busyOut        = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    sumDataOut     = acc_q;
    sumOverflowOut = ovf_q;
  end

endmodule

// File: doc/stream_accumulator.md
# stream_accumulator

- Downstream consumer of the accelerator's valid/ready word FIFO.
- Accepts a command giving a word count and signedness, then drains exactly that many 32-bit words from the FIFO read port.
- Sums the words into a wide accumulator and presents the sum, with a sticky overflow flag, on a registered valid/ready output for the result path.
- One command in flight at a time.

## Interface
- DATA_WIDTH, 32, width of input words (FIFO read data).
- ACC_WIDTH, 48, accumulator/sum width; must be >= DATA_WIDTH+1.
- LEN_WIDTH, 16, width of the command word count.

- clkIn  input  1  clock; all state changes on rising edge.
- rstIn  input  1  reset; asynchronous, active-high.
- cmdLenIn  input  LEN_WIDTH  number of words to sum.
- cmdSignedIn  input  1  1 = sign-extend words, 0 = zero-extend.
- cmdValidIn  input  1  command valid.
- cmdReadyOut  output  1  command ready; high only in IDLE.
- inDataIn  input  DATA_WIDTH  word from FIFO rdDataOut.
- inValidIn  input  1  from FIFO rdValidOut.
- inReadyOut  output  1  to FIFO rdReadyIn; high only in ACCUM.
- sumDataOut  output  ACC_WIDTH  accumulated sum (registered).
- sumOverflowOut  output  1  sticky overflow for this command.
- sumValidOut  output  1  result valid; high only in DONE.
- sumReadyIn  input  1  result consumer ready.
- busyOut  output  1  high in ACCUM or DONE.

## Operation
- States: IDLE, ACCUM, DONE. Reset state is IDLE.
- IDLE:
  - cmdReadyOut=1.
  - On cmdValidIn: latch length into remaining counter, latch signedness, clear accumulator and overflow.
  - Go to ACCUM if length != 0; go to DONE if length == 0 (sum 0, overflow 0).
- ACCUM:
  - inReadyOut=1. Beat = inValidIn & inReadyOut.
  - Each beat: acc <= acc + ext(inDataIn) mod 2^ACC_WIDTH, and remaining decrements.
  - Beat with remaining==1: accumulate, then go to DONE.
  - inValidIn low: hold all state; gaps of any length are legal.
- DONE:
  - sumValidOut=1; sumDataOut and sumOverflowOut stay stable while sumReadyIn=0.
  - On sumReadyIn: go to IDLE.
- Overflow, set sticky for the current command:
  - Unsigned: carry out of bit ACC_WIDTH-1.
  - Signed: both operands share a sign and the result sign differs.
- ext(): sign- or zero-extension of DATA_WIDTH to ACC_WIDTH per the latched signedness.
- Commands and input words never interact outside ACCUM. Words arriving in IDLE or DONE stay in the FIFO.

## Timing
- Reset values (asserted immediately and asynchronously): cmdReadyOut=1 once reset deasserts, with IDLE applied during reset. All other outputs are 0.
- Reset mid-ACCUM or mid-DONE: partial sum discarded; no result emitted. The FIFO shares rstIn and is flushed in the same event.
- Command accepted on edge N: inReadyOut high from cycle N+1.
- Last word accepted on edge M: sumValidOut high from cycle M+1, with the final sum already on sumDataOut.
- Result handshake on edge K: cmdReadyOut high from cycle K+1.
- Per-command overhead: 2 cycles plus length. Throughput in ACCUM: 1 word/cycle.
- Outputs are decoded from the registered state only: no combinational path from inValidIn or sumReadyIn to any output.

## Structure
- Package stream_acc_pkg holds:
  - state encoding constants (IDLE=0, ACCUM=1, DONE=2, 2-bit);
  - default width constants.
- Sub-module acc_add: purely combinational. Takes acc, word and signedness; produces extended sum and overflow. It is instanced once and verified standalone.
- The remaining RTL (FSM, remaining counter, registers) is in stream_accumulator.

## Test plan
- Unsigned, len=4: words 1,2,3,4 back-to-back, with inValidIn low for 3 cycles between words 2 and 3.
  - Required: sumDataOut=10 and overflow=0.
  - sumValidOut high exactly 1 cycle after the 4th beat.
- len=0: sumValidOut=1 on the cycle after command accept; sum=0; inReadyOut never asserts.
- Words 0xFFFFFFFF, 0x00000003 sent twice, first with cmdSignedIn=1, then with cmdSignedIn=0:
  - signed: sum=2;
  - unsigned: sum=0x000100000002.
  - Overflow=0 in both.
- ACC_WIDTH=33, unsigned, 3×0xFFFFFFFF: sum=0x0FFFFFFFD, overflow=1. The next command (len=1, word 5) returns 5 with overflow=0.
- Backpressure: sumReadyIn low for 10 cycles in DONE.
  - Sum stable; cmdReadyOut=0; inReadyOut=0; upstream FIFO keeps its queued words.
  - After release, the next command drains those words in order.
- rstIn pulsed asynchronously after 2 of 5 beats.
  - All outputs 0 during reset; state returns to IDLE.
  - A new command (len=1, word 7) yields sum 7.
